// File: rtl/w_coeff_loader.sv
// Serial-to-parallel coefficient loader: gathers N taps into a shadow bank and
// commits them to the active bank in one strobe once the filter is not busy.
module w_coeff_loader #(
  parameter int N       = 32,
  parameter int COEFF_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               coeff_valid,
  output logic               coeff_ready,
  input  logic [COEFF_W-1:0] coeff_data,
  input  logic               coeff_last,
  input  logic               filter_busy,
  output logic [COEFF_W-1:0] weight_out [0:N-1],
  output logic               weight_load_en,
  output logic               load_error
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [COEFF_W-1:0] shadow [0:N-1];
  logic               handshake;
  logic               at_end;

  assign handshake = coeff_valid && coeff_ready && (state == FILL);
  assign at_end    = (idx == LAST_IDX);

  // Shadow bank needs no reset: a frame is only committed after every tap is rewritten.
  always_ff @(posedge clock) begin
    if (handshake) begin
      shadow[idx] <= coeff_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= FILL;
      idx            <= '0;
      coeff_ready    <= 1'b0;
      weight_load_en <= 1'b0;
      load_error     <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        weight_out[i] <= '0;
      end
    end else begin
      weight_load_en <= 1'b0;
      load_error     <= 1'b0;
      case (state)
        FILL: begin
          coeff_ready <= 1'b1;
          if (handshake) begin
            if (coeff_last && at_end) begin
              state       <= PEND;
              idx         <= '0;
              coeff_ready <= 1'b0;
            end else if (coeff_last || at_end) begin
              // Early or missing last: drop the frame and restart at tap 0.
              load_error <= 1'b1;
              idx        <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        PEND: begin
          if (!filter_busy) begin
            for (int unsigned i = 0; i < N; i++) begin
              weight_out[i] <= shadow[i];
            end
            weight_load_en <= 1'b1;
            coeff_ready    <= 1'b1;
            state          <= FILL;
          end
        end
        default: begin
          state       <= FILL;
          coeff_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w_coeff_loader.sv
// Randomized bench for w_coeff_loader: a frame-level queue model predicts every
// output each cycle; literal checks pin key values and timings.
module tb_w_coeff_loader;

  localparam int N = 32;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         coeff_valid;
  logic         coeff_ready;
  logic [W-1:0] coeff_data;
  logic         coeff_last;
  logic         filter_busy;
  logic [W-1:0] weight_out [0:N-1];
  logic         weight_load_en;
  logic         load_error;

  w_coeff_loader #(.N(N), .COEFF_W(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .coeff_valid    (coeff_valid),
    .coeff_ready    (coeff_ready),
    .coeff_data     (coeff_data),
    .coeff_last     (coeff_last),
    .filter_busy    (filter_busy),
    .weight_out     (weight_out),
    .weight_load_en (weight_load_en),
    .load_error     (load_error)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int en_edge = 0;
  int first_edge = 0;
  int last_edge = 0;

  logic [W-1:0] dat [0:N-1];

  // Behavioural model: frame queue, pending vector and the committed bank.
  bit           m_ready, m_pend, m_en, m_err;
  logic [W-1:0] m_w    [0:N-1];
  logic [W-1:0] m_pvec [0:N-1];
  logic [W-1:0] frame  [$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_ready = 0; m_pend = 0; m_en = 0; m_err = 0;
      for (int i = 0; i < N; i++) m_w[i] = '0;
      frame.delete();
    end else begin
      m_en = 0; m_err = 0;
      if (m_pend) begin
        if (!filter_busy) begin
          for (int i = 0; i < N; i++) m_w[i] = m_pvec[i];
          m_en = 1; m_pend = 0; m_ready = 1;
        end
      end else begin
        if (m_ready && coeff_valid) begin
          frame.push_back(coeff_data);
          if (coeff_last && frame.size() == N) begin
            for (int i = 0; i < N; i++) m_pvec[i] = frame[i];
            frame.delete();
            m_pend = 1; m_ready = 0;
          end else if (coeff_last || frame.size() == N) begin
            frame.delete();
            m_err = 1; m_ready = 1;
          end else begin
            m_ready = 1;
          end
        end else begin
          m_ready = 1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      model_step();
    end
  end

  initial forever begin
    @(posedge clock);
    cycle++;
  end

  // Single compare process: every output against the model on each falling edge.
  initial forever begin
    @(negedge clock);
    chk("coeff_ready", {31'b0, coeff_ready}, {31'b0, m_ready});
    chk("weight_load_en", {31'b0, weight_load_en}, {31'b0, m_en});
    chk("load_error", {31'b0, load_error}, {31'b0, m_err});
    for (int i = 0; i < N; i++) chk($sformatf("weight_out[%0d]", i), weight_out[i], m_w[i]);
    if (weight_load_en === 1'b1) begin
      en_cnt++;
      en_edge = cycle;
    end
    if (load_error === 1'b1) err_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input int n, input bit last_on_final, input bit gaps);
    bit rdy;
    int waited;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        coeff_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      coeff_valid = 1'b1;
      coeff_data  = dat[i];
      coeff_last  = last_on_final && (i == n - 1);
      waited = 0;
      do begin
        rdy = coeff_ready;
        tick();
        waited++;
      end while (!rdy && waited < 100);
      if (!rdy) begin
        tests++; fails++;
        $display("FAIL send_timeout tap %0d: ready stayed 0, expected 1 within 100 cycles", i);
        coeff_valid = 1'b0;
        return;
      end
      if (i == 0) first_edge = cycle;
      if (i == n - 1) last_edge = cycle;
    end
    coeff_valid = 1'b0;
    coeff_last  = 1'b0;
    coeff_data  = $urandom;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) dat[i] = $urandom;
  endtask

  int en0, err0;

  initial begin
    reset = 1'b1; coeff_valid = 1'b1; coeff_data = '0; coeff_last = 1'b0; filter_busy = 1'b0;
    repeat (2) tick();
    chk("reset_ready", {31'b0, coeff_ready}, 32'd0);
    chk("reset_w31", weight_out[31], 32'd0);
    reset = 1'b0;
    coeff_valid = 1'b0;
    tick();
    chk("ready_after_release", {31'b0, coeff_ready}, 32'd1);

    // Basic load
    for (int i = 0; i < N; i++) dat[i] = 32'(i) * 32'h01010101;
    en0 = en_cnt;
    send(N, 1, 0);
    repeat (3) tick();
    chk("basic_en_count", 32'(en_cnt - en0), 32'd1);
    chk("basic_w0", weight_out[0], 32'h00000000);
    chk("basic_w31", weight_out[31], 32'h1F1F1F1F);
    chk("basic_first_to_strobe", 32'(en_edge - first_edge + 1), 32'd33);
    chk("basic_last_to_strobe", 32'(en_edge - last_edge), 32'd1);

    // Busy hold-off, with busy also high during fill where it must be ignored
    rand_frame();
    en0 = en_cnt;
    filter_busy = 1'b1;
    send(N, 1, 1);
    repeat (5) tick();
    chk("busy_no_commit", 32'(en_cnt - en0), 32'd0);
    chk("busy_w31_held", weight_out[31], 32'h1F1F1F1F);
    filter_busy = 1'b0;
    repeat (2) tick();
    chk("busy_strobe_edge", 32'(en_edge - last_edge), 32'd6);
    chk("busy_w5", weight_out[5], dat[5]);

    rand_frame();
    dat[0] = 32'hFE521EDD;
    dat[15] = 32'h4F89F36F;
    send(N, 1, 0);
    repeat (2) tick();
    chk("exact_w0", weight_out[0], 32'hFE521EDD);
    chk("exact_w15", weight_out[15], 32'h4F89F36F);

    // Early last
    rand_frame();
    en0 = en_cnt; err0 = err_cnt;
    send(10, 1, 1);
    repeat (3) tick();
    chk("early_err", 32'(err_cnt - err0), 32'd1);
    chk("early_no_en", 32'(en_cnt - en0), 32'd0);
    chk("early_w15_kept", weight_out[15], 32'h4F89F36F);
    rand_frame();
    send(N, 1, 1);
    repeat (2) tick();
    chk("after_early_en", 32'(en_cnt - en0), 32'd1);
    chk("after_early_w9", weight_out[9], dat[9]);

    // Missing last
    rand_frame();
    en0 = en_cnt; err0 = err_cnt;
    send(N, 0, 0);
    repeat (2) tick();
    chk("missing_err", 32'(err_cnt - err0), 32'd1);
    chk("missing_no_en", 32'(en_cnt - en0), 32'd0);
    rand_frame();
    send(N, 1, 0);
    repeat (2) tick();
    chk("after_missing_w0", weight_out[0], dat[0]);
    chk("after_missing_w31", weight_out[31], dat[31]);

    // Reset mid-frame with gaps, asserted between clock edges
    rand_frame();
    send(20, 0, 1);
    coeff_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_ready", {31'b0, coeff_ready}, 32'd0);
    chk("async_en", {31'b0, weight_load_en}, 32'd0);
    chk("async_w0", weight_out[0], 32'd0);
    repeat (2) tick();
    coeff_valid = 1'b0;
    reset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) dat[i] = 32'hA5A5A5A5;
    en0 = en_cnt;
    send(N, 1, 1);
    repeat (2) tick();
    chk("a5_en", 32'(en_cnt - en0), 32'd1);
    for (int i = 0; i < N; i++) chk($sformatf("a5_w%0d", i), weight_out[i], 32'hA5A5A5A5);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, expected completion before 2 ms");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
